// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: 8x8 transpose and rescale buffer between
// the row pass and the column pass of Y = D X D^T.
module dct_transpose_buf #(
  parameter int N     = 8,
  parameter int W     = 2*N+3,
  parameter int SHIFT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] Y0,
  input  logic [W-1:0] Y1,
  input  logic [W-1:0] Y2,
  input  logic [W-1:0] Y3,
  input  logic [W-1:0] Y4,
  input  logic [W-1:0] Y5,
  input  logic [W-1:0] Y6,
  input  logic [W-1:0] Y7,
  output logic [N-1:0] A0,
  output logic [N-1:0] A1,
  output logic [N-1:0] A2,
  output logic [N-1:0] A3,
  output logic [N-1:0] A4,
  output logic [N-1:0] A5,
  output logic [N-1:0] A6,
  output logic [N-1:0] A7,
  output logic         start,
  input  logic         done,
  output logic         frame_done
);

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT
  } state_t;

  localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [W:0] RND =
    (SHIFT > 0) ? ((W+1)'(1) << SH1) : '0;

  localparam logic signed [W:0] MAXV =
    (W+1)'((1 << (N-1)) - 1);

  localparam logic signed [W:0] MINV = ~MAXV;

  // Round half up, arithmetic shift, clamp to N bits.
  // One extra bit keeps the rounding add from wrapping.
  function automatic logic [N-1:0] scale(
    input logic [W-1:0] x
  );
    logic signed [W:0] t;
    t = $signed({x[W-1], x}) + RND;
    t = t >>> SHIFT;
    if (t > MAXV)
      scale = MAXV[N-1:0];
    else if (t < MINV)
      scale = MINV[N-1:0];
    else
      scale = t[N-1:0];
  endfunction

  state_t       state;
  logic [2:0]   r;
  logic [2:0]   c;
  logic [W-1:0] m [8][8];
  logic [W-1:0] y [8];
  logic [N-1:0] a [8];
  logic [2:0]   col_sel;
  logic [W-1:0] col_raw [8];
  logic         wr;

  assign y[0] = Y0;
  assign y[1] = Y1;
  assign y[2] = Y2;
  assign y[3] = Y3;
  assign y[4] = Y4;
  assign y[5] = Y5;
  assign y[6] = Y6;
  assign y[7] = Y7;

  assign A0 = a[0];
  assign A1 = a[1];
  assign A2 = a[2];
  assign A3 = a[3];
  assign A4 = a[4];
  assign A5 = a[5];
  assign A6 = a[6];
  assign A7 = a[7];

  assign in_ready = (state == FILL);
  assign wr       = in_valid && in_ready;

  // Row capture; the array needs no reset since
  // a frame is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int k = 0; k < 8; k++)
        m[r][k] <= y[k];
    end
  end

  // Next column to present: column 0 at the end
  // of a fill (row 7 still on the inputs), else c+1.
  always_comb begin
    col_sel = (state == FILL) ? 3'd0 : c + 3'd1;
    for (int k = 0; k < 8; k++)
      col_raw[k] = m[k][col_sel];
    if (state == FILL)
      col_raw[7] = y[0];
  end

  // Fill / issue / wait sequencing with
  // registered operands, start and frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      r          <= '0;
      c          <= '0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 8; k++)
        a[k] <= '0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        FILL: begin
          if (in_valid) begin
            r <= r + 3'd1;
            if (r == 3'd7) begin
              state <= ISSUE;
              start <= 1'b1;
              for (int k = 0; k < 8; k++)
                a[k] <= scale(col_raw[k]);
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            if (c != 3'd7) begin
              c     <= c + 3'd1;
              state <= ISSUE;
              start <= 1'b1;
              for (int k = 0; k < 8; k++)
                a[k] <= scale(col_raw[k]);
            end else begin
              c          <= '0;
              frame_done <= 1'b1;
              state      <= FILL;
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
